timer_slave: RTL and testbench
==============================

TIMER_SLAVE -- requirements
Module: timer_slave

Interface
REQ-001 Parameter: EXPR_RESET, 32'h0000_0000, reset value of the expiry register.
REQ-002 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset_  in  1  asynchronous, active-low reset.
REQ-004 Port: cs_  in  1  chip select from the bus address decoder, active-low.
REQ-005 Port: as_  in  1  address strobe, active-low.
REQ-006 Port: rw  in  1  1 = read, 0 = write.
REQ-007 Port: addr  in  2  word register index: 0 CTRL, 1 INTR, 2 EXPR, 3 COUNTER.
REQ-008 Port: wr_data  in  32  write data.
REQ-009 Port: rd_data  out  32  read data; valid only while rdy_ is low, otherwise 0.
REQ-010 Port: rdy_  out  1  response ready, active-low, low for one cycle per access.
REQ-011 Port: irq  out  1  interrupt request, active-high, equals the INTR flag.

Function
REQ-012 An access SHALL occur in any cycle where cs_=0 and as_=0 while the response FSM is in IDLE.
REQ-013 The response FSM SHALL have states IDLE and RESP: IDLE->RESP on access; RESP->IDLE unconditionally.
REQ-014 rdy_ SHALL be low only in RESP, giving one-cycle latency from the access edge to rdy_ low.
REQ-015 Strobes seen in RESP (or WAIT) SHALL be ignored: no register update and no extra response.
REQ-016 A write SHALL update the addressed register at the access clock edge; a read SHALL capture the addressed register at that edge and present it on rd_data during RESP.
REQ-017 CTRL bit0 = start and bit1 = periodic; bits 31:2 SHALL read 0.
REQ-018 INTR bit0 = irq flag; bits 31:1 SHALL read 0. A write SHALL load bit0 from wr_data[0].
REQ-019 While start=1 and COUNTER != EXPR, COUNTER SHALL increment by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0.
REQ-020 While start=1 and COUNTER == EXPR: COUNTER SHALL go to 0, the INTR flag SHALL go to 1, and start SHALL go to 0 when periodic=0.
REQ-021 While start=0, COUNTER SHALL hold.
REQ-022 If a bus write to COUNTER or CTRL coincides with expiry or an increment, the bus write SHALL win for that register.
REQ-023 If an expiry coincides with a bus write of 0 to INTR, the flag SHALL end at 1.
REQ-024 With EXPR = 0 and start=1, expiry SHALL occur every cycle.

Reset
REQ-025 When reset_ is low, the block SHALL asynchronously set CTRL=0, INTR=0, COUNTER=0, EXPR=EXPR_RESET, FSM=IDLE, rdy_=1, rd_data=0, irq=0.
REQ-026 A reset during RESP or WAIT SHALL drop the pending response with no rdy_ pulse.

Configuration
REQ-027 With TIMER_WAIT_STATE_EN defined, the FSM SHALL be IDLE->WAIT->RESP->IDLE, with rdy_ low on the second cycle after the access. Read data SHALL still be captured at the access edge.
REQ-028 Without TIMER_WAIT_STATE_EN, the WAIT state SHALL NOT exist and REQ-013/REQ-014 timing SHALL apply.

Structure
REQ-029 The shared define file SHALL hold the register index constants, the CTRL/INTR bit positions, the FSM state encodings, and the existing Enable_/Disable_ and bus width defines.
REQ-030 The block SHALL be a single module; the response FSM and the counter core SHALL be separate always blocks, with no sub-module.

Verification
REQ-031 Reset, then read EXPR -> rdy_ low exactly 1 cycle after the strobe, rd_data=EXPR_RESET, rd_data=0 the following cycle.
REQ-032 Write EXPR=5, then write CTRL=3'b011 (start, periodic) -> irq rises after the 6th counting cycle; COUNTER sequence is 0..5,0,...; start remains 1.
REQ-033 Write EXPR=3, then CTRL=1 (one-shot) -> irq=1 after the 4th count, CTRL reads 0, COUNTER holds 0.
REQ-034 Write INTR=0 on the same edge as an expiry -> irq stays 1; a subsequent INTR=0 write -> irq=0.
REQ-035 Write COUNTER=32'hFFFF_FFFF with EXPR=1 and start=1 -> COUNTER wraps to 0, then 1, then expiry.
REQ-036 Assert reset_ during RESP -> no rdy_ pulse and all registers at reset values; with TIMER_WAIT_STATE_EN, rdy_ low 2 cycles after the strobe, and a second strobe during WAIT is ignored.

Source files
------------

// File: rtl/timer_slave_pkg.sv
// Shared definitions for timer_slave: bus widths, active-low levels,
// register indices, CTRL/INTR bit positions and response FSM encodings.
// The WAIT state only exists when TIMER_WAIT_STATE_EN is defined.
package timer_slave_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 2;

  // Levels for the active-low strobes and ready
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Word register indices
  localparam logic [ADDR_WIDTH-1:0] REG_CTRL    = 2'd0;
  localparam logic [ADDR_WIDTH-1:0] REG_INTR    = 2'd1;
  localparam logic [ADDR_WIDTH-1:0] REG_EXPR    = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] REG_COUNTER = 2'd3;

  // Bit positions inside CTRL and INTR
  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int INTR_FLAG_BIT     = 0;

  // Response FSM encodings
`ifdef TIMER_WAIT_STATE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_WAIT = 2'b10
  } resp_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01
  } resp_state_e;
`endif

  // Read image of CTRL: unused upper bits read as zero
  function automatic logic [BUS_WIDTH-1:0] pack_ctrl(input logic start, input logic periodic);
    logic [BUS_WIDTH-1:0] word;
    word = {BUS_WIDTH{1'b0}};
    word[CTRL_START_BIT]    = start;
    word[CTRL_PERIODIC_BIT] = periodic;
    return word;
  endfunction

  // Read image of INTR: only the flag bit is populated
  function automatic logic [BUS_WIDTH-1:0] pack_intr(input logic flag);
    logic [BUS_WIDTH-1:0] word;
    word = {BUS_WIDTH{1'b0}};
    word[INTR_FLAG_BIT] = flag;
    return word;
  endfunction

endpackage

// File: rtl/timer_slave.sv
// timer_slave: bus-accessible 32-bit timer with CTRL/INTR/EXPR/COUNTER
// registers, a one-cycle (or two-cycle) rdy_ response and a level irq.
// Optional macro TIMER_WAIT_STATE_EN inserts a WAIT state so that rdy_
// falls on the second cycle after the access; read data is still sampled
// at the access edge.
module timer_slave
  import timer_slave_pkg::*;
#(
  parameter logic [31:0] EXPR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  resp_state_e   state_r;
  logic          rdy_r;
  logic [31:0]   rd_data_r;
`ifdef TIMER_WAIT_STATE_EN
  logic [31:0]   rd_hold_r;
`endif

  logic          start_r;
  logic          periodic_r;
  logic          intr_r;
  logic [31:0]   expr_r;
  logic [31:0]   counter_r;

  logic          access_s;
  logic          wr_s;
  logic          expire_s;
  logic [31:0]   rd_mux_s;
  logic [31:0]   resp_data_s;

  // Strobes are only honoured while the responder is idle
  assign access_s = (state_r == ST_IDLE) && (cs_ == ENABLE_) && (as_ == ENABLE_);
  assign wr_s     = access_s && (rw == 1'b0);
  assign expire_s = start_r && (counter_r == expr_r);

  // Select the addressed register for a read
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (addr)
      REG_CTRL:    rd_mux_s = pack_ctrl(start_r, periodic_r);
      REG_INTR:    rd_mux_s = pack_intr(intr_r);
      REG_EXPR:    rd_mux_s = expr_r;
      REG_COUNTER: rd_mux_s = counter_r;
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Writes return zero so rd_data never carries stale register contents
  always_comb begin
    resp_data_s = 32'h0000_0000;
    if (rw == 1'b1) begin
      resp_data_s = rd_mux_s;
    end else begin
      resp_data_s = 32'h0000_0000;
    end
  end

  // Response FSM: registered rdy_ and rd_data, one pulse per access
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r   <= ST_IDLE;
      rdy_r     <= DISABLE_;
      rd_data_r <= 32'h0000_0000;
`ifdef TIMER_WAIT_STATE_EN
      rd_hold_r <= 32'h0000_0000;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s) begin
`ifdef TIMER_WAIT_STATE_EN
            state_r   <= ST_WAIT;
            rd_hold_r <= resp_data_s;
            rdy_r     <= DISABLE_;
            rd_data_r <= 32'h0000_0000;
`else
            state_r   <= ST_RESP;
            rdy_r     <= ENABLE_;
            rd_data_r <= resp_data_s;
`endif
          end else begin
            state_r   <= ST_IDLE;
            rdy_r     <= DISABLE_;
            rd_data_r <= 32'h0000_0000;
          end
        end
`ifdef TIMER_WAIT_STATE_EN
        ST_WAIT: begin
          state_r   <= ST_RESP;
          rdy_r     <= ENABLE_;
          rd_data_r <= rd_hold_r;
        end
`endif
        ST_RESP: begin
          state_r   <= ST_IDLE;
          rdy_r     <= DISABLE_;
          rd_data_r <= 32'h0000_0000;
        end
        default: begin
          state_r   <= ST_IDLE;
          rdy_r     <= DISABLE_;
          rd_data_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Counter core: bus writes override counting and expiry for their register,
  // except that an expiry always leaves the interrupt flag set
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      start_r    <= 1'b0;
      periodic_r <= 1'b0;
      intr_r     <= 1'b0;
      expr_r     <= EXPR_RESET;
      counter_r  <= 32'h0000_0000;
    end else begin
      if (wr_s && (addr == REG_COUNTER)) begin
        counter_r <= wr_data;
      end else if (expire_s) begin
        counter_r <= 32'h0000_0000;
      end else if (start_r) begin
        counter_r <= counter_r + 32'h0000_0001;
      end else begin
        counter_r <= counter_r;
      end

      if (wr_s && (addr == REG_CTRL)) begin
        start_r    <= wr_data[CTRL_START_BIT];
        periodic_r <= wr_data[CTRL_PERIODIC_BIT];
      end else if (expire_s && !periodic_r) begin
        start_r    <= 1'b0;
        periodic_r <= periodic_r;
      end else begin
        start_r    <= start_r;
        periodic_r <= periodic_r;
      end

      if (expire_s) begin
        intr_r <= 1'b1;
      end else if (wr_s && (addr == REG_INTR)) begin
        intr_r <= wr_data[INTR_FLAG_BIT];
      end else begin
        intr_r <= intr_r;
      end

      if (wr_s && (addr == REG_EXPR)) begin
        expr_r <= wr_data;
      end else begin
        expr_r <= expr_r;
      end
    end
  end

  assign rdy_    = rdy_r;
  assign rd_data = rd_data_r;
  assign irq     = intr_r;

endmodule

// File: tb/tb_timer_slave.sv
// Directed self-checking bench for timer_slave. Read expectations go into a
// scoreboard queue when the access is driven and are popped when rdy_ falls.
// Counter expectations are derived from the edge number of the access.
module tb_timer_slave;
  import timer_slave_pkg::*;

  localparam logic [31:0] TB_EXPR_RESET = 32'h1234_5678;
`ifdef TIMER_WAIT_STATE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_no  = 0;
  logic [31:0] exp_q[$];

  timer_slave #(.EXPR_RESET(TB_EXPR_RESET)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Number the rising edges so counter values can be predicted
  always @(posedge clk) edge_no <= edge_no + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: fixed base; 1: base + cycles since ref edge; 2: periodic count mod modn
  task automatic bus_access(input logic r, input logic [1:0] a, input logic [31:0] d,
                            input int mode, input logic [31:0] base, input int ref_e,
                            input int modn, output int acc_e);
    int          lat;
    int          pred;
    logic [31:0] exp;
    @(negedge clk);
    pred = edge_no + 1;
    exp  = base;
    if (r) begin
      case (mode)
        1:       exp = base + 32'(pred - 1 - ref_e);
        2:       exp = 32'((pred - 1 - ref_e) % modn);
        default: exp = base;
      endcase
      exp_q.push_back(exp);
    end
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1;
    acc_e = edge_no;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (rdy_ === 1'b0) begin
        lat = i;
        break;
      end
    end
    check("rdy_latency", lat, EXP_LAT);
    if (lat != 0) begin
      if (r) begin
        exp = exp_q.pop_front();
        check("rd_data", rd_data, exp);
      end
      @(negedge clk);
      check("rdy_release", {31'h0, rdy_}, 32'h1);
      check("rd_data_idle", rd_data, 32'h0);
    end else if (r) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int e;
    bus_access(1'b0, a, d, 0, 32'h0, 0, 1, e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    int e;
    bus_access(1'b1, a, 32'h0, 0, exp, 0, 1, e);
  endtask

  // Write CTRL and count falling edges until irq is seen high
  task automatic start_timed(input logic [31:0] ctrl, output int rise_n, output int s_edge);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = REG_CTRL; wr_data = ctrl;
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1;
    s_edge = edge_no;
    rise_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (irq === 1'b1) begin
        rise_n = n;
        break;
      end
    end
  endtask

  initial begin
    int n, s, p, w, e, lows, first;
    logic [31:0] held;
    reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wr_data = 32'h0;
    #22;
    check("reset_rdy", {31'h0, rdy_}, 32'h1);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;

    // Reset values through the bus
    rd(REG_EXPR, TB_EXPR_RESET);
    rd(REG_CTRL, 32'h0);
    rd(REG_INTR, 32'h0);
    rd(REG_COUNTER, 32'h0);

    // Periodic mode with EXPR=5
    wr(REG_EXPR, 32'd5);
    start_timed(32'h3, n, s);
    check("periodic_first_expiry", n, 32'd7);
    bus_access(1'b1, REG_COUNTER, 32'h0, 2, 32'h0, s, 6, e);
    bus_access(1'b1, REG_COUNTER, 32'h0, 2, 32'h0, s, 6, e);
    rd(REG_CTRL, 32'h3);
    rd(REG_INTR, 32'h1);
    bus_access(1'b0, REG_CTRL, 32'h0, 0, 32'h0, 0, 1, p);
    held = 32'((p - s) % 6);
    rd(REG_COUNTER, held);
    repeat (5) @(negedge clk);
    rd(REG_COUNTER, held);
    wr(REG_INTR, 32'h0);
    check("intr_clear", {31'h0, irq}, 32'h0);

    // EXPR=0: expiry every cycle; clearing INTR on an expiry edge keeps it set
    wr(REG_COUNTER, 32'h0);
    wr(REG_EXPR, 32'h0);
    wr(REG_CTRL, 32'h3);
    check("expr0_irq", {31'h0, irq}, 32'h1);
    wr(REG_INTR, 32'h0);
    check("intr_clear_vs_expiry", {31'h0, irq}, 32'h1);
    rd(REG_CTRL, 32'h3);
    rd(REG_COUNTER, 32'h0);
    wr(REG_CTRL, 32'h0);
    check("stop_edge_expiry", {31'h0, irq}, 32'h1);
    wr(REG_INTR, 32'h0);
    check("intr_clear_stopped", {31'h0, irq}, 32'h0);

    // One-shot with EXPR=3
    wr(REG_EXPR, 32'd3);
    wr(REG_COUNTER, 32'h0);
    start_timed(32'h1, n, s);
    check("oneshot_expiry", n, 32'd5);
    rd(REG_CTRL, 32'h0);
    rd(REG_COUNTER, 32'h0);
    repeat (4) @(negedge clk);
    rd(REG_COUNTER, 32'h0);
    check("oneshot_irq_held", {31'h0, irq}, 32'h1);
    wr(REG_INTR, 32'h0);

    // Wrap from all-ones with EXPR=1
    wr(REG_EXPR, 32'd1);
    wr(REG_COUNTER, 32'hFFFF_FFFF);
    rd(REG_COUNTER, 32'hFFFF_FFFF);
    start_timed(32'h1, n, s);
    check("wrap_expiry", n, 32'd4);
    rd(REG_CTRL, 32'h0);
    rd(REG_COUNTER, 32'h0);

    // Bus writes to COUNTER and CTRL win over counting
    wr(REG_INTR, 32'h0);
    wr(REG_EXPR, 32'd1000);
    wr(REG_COUNTER, 32'h0);
    wr(REG_CTRL, 32'h1);
    bus_access(1'b0, REG_COUNTER, 32'h100, 0, 32'h0, 0, 1, w);
    bus_access(1'b1, REG_COUNTER, 32'h0, 1, 32'h100, w, 1, e);
    bus_access(1'b0, REG_CTRL, 32'h0, 0, 32'h0, 0, 1, p);
    rd(REG_COUNTER, 32'h100 + 32'(p - w));
    rd(REG_CTRL, 32'h0);

    // Reset while a response is pending
    wr(REG_INTR, 32'h1);
    check("intr_set_by_write", {31'h0, irq}, 32'h1);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = REG_EXPR;
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    if (EXP_LAT == 1) check("pre_reset_rdy_low", {31'h0, rdy_}, 32'h0);
    reset_ = 1'b0;
    #1;
    check("reset_resp_rdy", {31'h0, rdy_}, 32'h1);
    check("reset_resp_rd_data", rd_data, 32'h0);
    check("reset_resp_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy_ === 1'b0) lows++;
    end
    check("no_pulse_after_reset", lows, 32'd0);
    rd(REG_EXPR, TB_EXPR_RESET);
    rd(REG_CTRL, 32'h0);
    rd(REG_INTR, 32'h0);
    rd(REG_COUNTER, 32'h0);

    // Strobe held through RESP/WAIT: one response, second strobe ignored
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = REG_EXPR;
    lows = 0; first = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (rdy_ === 1'b0) begin
        lows++;
        if (first == 0) first = i;
        check("held_rd_data", rd_data, TB_EXPR_RESET);
      end
      if (i == 1) begin
        rw = 1'b0; wr_data = 32'd77;
      end else begin
        cs_ = 1'b1; as_ = 1'b1;
      end
    end
    check("held_pulse_count", lows, 32'd1);
    check("held_pulse_latency", first, EXP_LAT);
    rd(REG_EXPR, TB_EXPR_RESET);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
